fp_accumulator: RTL and testbench
=================================

Name: fp_accumulator

Overview:
- Sequential controller that sums a stream of positive single-precision floats, one per accepted input beat.
- Sits directly around the combinational FloatingPointAdder, which is instantiated externally.
- Drives the adder's operand inputs from a running accumulator and the incoming element, then captures the adder's Out back into the accumulator.
- Presents the final sum on a valid/ready output port.

Parameters:
- CNT_W, 8, width of the element-count field; maximum run length is 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a run (sampled in IDLE only)
- len  input  CNT_W  number of elements in the run, sampled with start
- in_valid  input  1  in_data is valid
- in_data  input  32  IEEE-754 single-precision element
- in_ready  output  1  block accepts in_data this cycle
- add_a  output  32  adder operand A (accumulator)
- add_b  output  32  adder operand B (element)
- add_sum  input  32  adder result Out, combinational from add_a/add_b
- out_valid  output  1  out_data holds the final sum
- out_data  output  32  final sum
- out_ready  input  1  consumer accepts out_data
- busy  output  1  high in any state other than IDLE
- err  output  1  sticky error flag for the current run

Behaviour:
- Reset (async, rst_n=0): state=IDLE; acc=0; cnt=0; first=0; in_ready=0; out_valid=0; out_data=0; busy=0; err=0; add_a=0; add_b=0.
- States: IDLE, ACC, HOLD. WAIT exists only with the optional feature.
- IDLE:
  - On start=1 with len!=0: cnt<=len; first<=1; err<=0; go to ACC.
  - On start=1 with len==0: acc<=32'h0; err<=0; go to HOLD.
- ACC:
  - in_ready=1; add_a=acc; add_b=in_data.
  - Accept occurs when in_valid && in_ready.
  - On accept with first=1: acc<=in_data directly; the adder result is ignored because the adder always inserts a hidden 1, so adding to a zero accumulator would be wrong. Then first<=0.
  - On accept with first=0: acc<=add_sum, captured in the same cycle.
  - On every accept: cnt<=cnt-1. If cnt==1, go to HOLD.
  - No accept: hold all state.
- HOLD:
  - out_valid=1; out_data=acc; in_ready=0.
  - On out_ready=1: go to IDLE. out_valid drops the next cycle.
- start outside IDLE is ignored. in_ready is 0 outside ACC. add_a/add_b are driven in every state but are only meaningful in ACC.
- err is sticky until the next start. It is set on any accepted element with in_data[31]=1 (negative), or in_data[30:23]==8'hFF (Inf/NaN). It is also set on any captured add_sum with exponent 8'hFF (overflow).
- Offending data is still accumulated unchanged; there is no saturation.
- Latency: out_valid rises on the cycle after the last accept. Throughput is 1 element/cycle.
- Simultaneous events:
  - start and out_ready in the same HOLD cycle: only the return to IDLE happens; start is dropped.
  - rst_n asserted mid-run: the run aborts immediately to reset values; no partial result is presented.

Optional Feature:
- Macro FPACC_PIPE_EN.
- Defined:
  - Inserts WAIT. On a non-first accept, in_data is registered into opb_q and the block goes to WAIT, with in_ready=0.
  - In WAIT: add_a=acc, add_b=opb_q; acc<=add_sum. Return to ACC, or go to HOLD if the element was the last.
  - This breaks the combinational loop through the adder. Throughput is 1 element/2 cycles (first element still 1 cycle). Result latency is +1 cycle.
- Undefined: single-cycle capture as described above; WAIT and opb_q are absent.

Test Plan:
- len=2, elements 0x3F800000, 0x40000000 (1.0+2.0) -> out_data=0x40400000 one cycle after second accept; err=0.
- len=3, elements 0x3F800000, 0x3F800000, 0x40000000 (1.0+1.0+2.0) -> out_data=0x40800000; also check 0x40000000 in acc after beat 2.
- len=1, element 0x3FC00000 -> out_data=0x3FC00000 (first-element bypass, adder unused); len=0 -> out_valid the cycle after start with out_data=0x00000000.
- Backpressure: in_valid toggled 1,0,1 and out_ready held 0 for 5 cycles -> in_ready only in ACC, out_valid/out_data stable for all 5 cycles, return to IDLE the cycle after out_ready=1; start pulsed during HOLD is ignored.
- len=2, elements 0xBF800000, 0x3F800000 -> err=1 at completion; next start clears err to 0.
- Reset mid-run: rst_n=0 after first accept of len=4 -> busy, in_ready, out_valid and err all 0 immediately; new run len=1 with 0x40000000 -> out_data=0x40000000. Repeat all scenarios with FPACC_PIPE_EN defined, checking the extra WAIT cycle per element.

Source files
------------

// File: rtl/fp_accumulator.sv
// fp_accumulator
// Sums a stream of positive single-precision floats, one element per accepted
// beat. The floating-point addition is done by an external combinational
// adder: this block drives its operands (add_a = running total, add_b =
// element) and captures its result (add_sum) back into the running total.
// The finished sum is offered on a valid/ready output port.
//
// Optional build macro: FPACC_PIPE_EN
//    When defined, each non-first element is registered first and added in a
//    separate WAIT cycle. This removes the combinational path from in_data
//    through the adder back into the accumulator, at half the throughput.
//
// Ports:
//    clk        rising-edge clock
//    rst_n      asynchronous active-low reset
//    start      one-cycle pulse that begins a run (only honoured in IDLE)
//    len        number of elements in the run, sampled with start
//    in_valid   in_data is valid
//    in_data    IEEE-754 single-precision element
//    in_ready   element is accepted this cycle when in_valid is also high
//    add_a      adder operand A (running total)
//    add_b      adder operand B (element)
//    add_sum    adder result, combinational from add_a/add_b
//    out_valid  out_data holds the final sum
//    out_data   final sum
//    out_ready  consumer accepts out_data
//    busy       high whenever the block is not IDLE
//    err        sticky error flag for the current run
module fp_accumulator #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   output logic             in_ready,
   output logic [31:0]      add_a,
   output logic [31:0]      add_b,
   input  logic [31:0]      add_sum,
   output logic             out_valid,
   output logic [31:0]      out_data,
   input  logic             out_ready,
   output logic             busy,
   output logic             err
);

`ifdef FPACC_PIPE_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2,
      WAIT = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;
`endif

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   state_t           nextstate;
   logic [31:0]      acc;
   logic [CNT_W-1:0] cnt;
   logic             first;
   logic             accept;
   logic             badin;
   logic             sumovf;
`ifdef FPACC_PIPE_EN
   logic [31:0]      opbq;
`endif

   // An element is taken whenever we sit in ACC and the producer offers one;
   // in_ready is unconditionally high in ACC so it need not be re-tested.
   // Negative, infinite and NaN inputs flag an error, as does an adder result
   // whose exponent saturated to all-ones.
   assign accept = (state == ACC) && in_valid;
   assign badin  = in_data[31] || (in_data[30:23] == 8'hFF);
   assign sumovf = (add_sum[30:23] == 8'hFF);

   // State register. Reset aborts any run in progress so no partial sum is
   // ever presented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextstate;
      end
   end

   // Next-state and output decode. The adder operands are always driven so
   // the external adder never sees X, but they only matter in ACC (and WAIT).
   // The final sum is only exposed on out_data while it is being offered.
   always_comb begin
      nextstate = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = 32'h0;
      add_a     = acc;
      add_b     = 32'h0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (start) begin
               nextstate = (len != '0) ? ACC : HOLD;
            end
         end
         ACC: begin
            in_ready = 1'b1;
            add_b    = in_data;
            if (in_valid) begin
`ifdef FPACC_PIPE_EN
               if (!first) begin
                  nextstate = WAIT;
               end else if (cnt == CNT_ONE) begin
                  nextstate = HOLD;
               end
`else
               if (cnt == CNT_ONE) begin
                  nextstate = HOLD;
               end
`endif
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            out_data  = acc;
            if (out_ready) begin
               nextstate = IDLE;
            end
         end
`ifdef FPACC_PIPE_EN
         WAIT: begin
            add_b     = opbq;
            nextstate = (cnt == '0) ? HOLD : ACC;
         end
`endif
         default: begin
            nextstate = IDLE;
         end
      endcase
   end

   // Accumulator datapath. The first element of a run bypasses the adder:
   // the external adder always assumes a hidden leading 1, so adding to a
   // zero total would not return the element unchanged. Offending values are
   // still accumulated as-is; err only records that something went wrong.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= 32'h0;
         cnt   <= '0;
         first <= 1'b0;
         err   <= 1'b0;
`ifdef FPACC_PIPE_EN
         opbq  <= 32'h0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  err <= 1'b0;
                  if (len != '0) begin
                     cnt   <= len;
                     first <= 1'b1;
                  end else begin
                     acc <= 32'h0;
                  end
               end
            end
            ACC: begin
               if (accept) begin
                  cnt   <= cnt - CNT_ONE;
                  first <= 1'b0;
                  if (badin) begin
                     err <= 1'b1;
                  end
                  if (first) begin
                     acc <= in_data;
                  end else begin
`ifdef FPACC_PIPE_EN
                     opbq <= in_data;
`else
                     acc <= add_sum;
                     if (sumovf) begin
                        err <= 1'b1;
                     end
`endif
                  end
               end
            end
`ifdef FPACC_PIPE_EN
            WAIT: begin
               acc <= add_sum;
               if (sumovf) begin
                  err <= 1'b1;
               end
            end
`endif
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_accumulator.sv
// tb_fp_accumulator
// Directed bench for fp_accumulator. The bench also plays the external
// floating-point adder (magnitude add with hidden 1, truncating alignment,
// exponent saturating to all-ones). Each run's expected sum and error flag
// are computed up front by folding the elements through that adder and
// queued; a single compare process checks every offered result against the
// queue, while the scenarios pin timing and a few literal values.
module tb_fp_accumulator;

   localparam int CNT_W = 8;
`ifdef FPACC_PIPE_EN
   localparam int PIPE = 1;
`else
   localparam int PIPE = 0;
`endif

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [CNT_W-1:0] len;
   logic             in_valid;
   logic [31:0]      in_data;
   logic             in_ready;
   logic [31:0]      add_a;
   logic [31:0]      add_b;
   logic [31:0]      add_sum;
   logic             out_valid;
   logic [31:0]      out_data;
   logic             out_ready;
   logic             busy;
   logic             err;

   int               checks = 0;
   int               errors = 0;
   logic [31:0]      vec[$];
   logic [31:0]      expSum[$];
   logic             expErr[$];
   logic [31:0]      curSum = 32'h0;
   logic             curErr = 1'b0;
   logic             prevOv = 1'b0;

   fp_accumulator #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_sum   (add_sum),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy),
      .err       (err)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the external adder: positive magnitudes, hidden 1 always
   // inserted, smaller operand shifted right with truncation.
   function automatic logic [31:0] fpAdd(input logic [31:0] a, input logic [31:0] b);
      logic [24:0] ma;
      logic [24:0] mb;
      logic [24:0] s;
      int          ea;
      int          eb;
      int          e;
      int          sh;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      ma = {2'b01, a[22:0]};
      mb = {2'b01, b[22:0]};
      if (ea >= eb) begin
         sh = ea - eb;
         e  = ea;
         s  = ma + ((sh > 24) ? 25'd0 : (mb >> sh));
      end else begin
         sh = eb - ea;
         e  = eb;
         s  = mb + ((sh > 24) ? 25'd0 : (ma >> sh));
      end
      if (s[24]) begin
         s = s >> 1;
         e = e + 1;
      end
      if (e >= 255) begin
         return 32'h7F800000;
      end
      return {1'b0, e[7:0], s[22:0]};
   endfunction

   // The adder is combinational from the operands the DUT drives.
   always_comb add_sum = fpAdd(add_a, add_b);

   // One comparison: bumps the check count, reports and counts a failure.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   // Scoreboard compare: each newly offered result must match the head of
   // the expectation queue, and must stay put for as long as it is offered.
   always @(negedge clk) begin
      if (!rst_n) begin
         prevOv = 1'b0;
      end else begin
         if (out_valid && !prevOv) begin
            if (expSum.size() == 0) begin
               checkOutput("unexpectedResult", 32'(out_valid), 32'd0);
            end else begin
               curSum = expSum.pop_front();
               curErr = expErr.pop_front();
               checkOutput("resultData", out_data, curSum);
               checkOutput("resultErr", 32'(err), 32'(curErr));
            end
         end else if (out_valid) begin
            checkOutput("resultStable", out_data, curSum);
         end
         checkOutput("readyValidExclusive", 32'(in_ready && out_valid), 32'd0);
         prevOv = out_valid;
      end
   end

   // Queue the model's answer for the elements in vec, then pulse start.
   task automatic startRun();
      logic [31:0] s;
      logic        e;
      s = 32'h0;
      e = 1'b0;
      foreach (vec[i]) begin
         if (vec[i][31] || (vec[i][30:23] == 8'hFF)) e = 1'b1;
         if (i == 0) begin
            s = vec[i];
         end else begin
            s = fpAdd(s, vec[i]);
            if (s[30:23] == 8'hFF) e = 1'b1;
         end
      end
      expSum.push_back(s);
      expErr.push_back(e);
      start = 1'b1;
      len   = CNT_W'(vec.size());
      @(negedge clk);
      start = 1'b0;
      checkOutput("busyAfterStart", 32'(busy), 32'd1);
   endtask

   // Offer one element and hold it until the DUT takes it (bounded).
   task automatic applyStimulus(input logic [31:0] d);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("inReadyArrives", 32'(in_ready), 32'd1);
      @(negedge clk);
   endtask

   task automatic sendAll();
      foreach (vec[i]) applyStimulus(vec[i]);
      in_valid = 1'b0;
      in_data  = 32'h0;
   endtask

   // After the last accept: result appears after the expected latency and
   // matches hand-computed literals.
   task automatic expectDone(input logic [31:0] litSum, input logic litErr);
      int n;
      int extra;
      n     = 0;
      extra = (PIPE != 0 && vec.size() >= 2) ? 1 : 0;
      while (!out_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("resultLatency", 32'(n), 32'(extra));
      checkOutput("sumLiteral", out_data, litSum);
      checkOutput("errLiteral", 32'(err), 32'(litErr));
   endtask

   task automatic finishRun();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("idleAfterAck", 32'(busy), 32'd0);
      checkOutput("validDropped", 32'(out_valid), 32'd0);
   endtask

   // Watchdog so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed scenarios.
   initial begin
      int n;
      rst_n     = 1'b0;
      start     = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      in_data   = 32'h0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstInReady", 32'(in_ready), 32'd0);
      checkOutput("rstOutValid", 32'(out_valid), 32'd0);
      checkOutput("rstOutData", out_data, 32'h0);
      checkOutput("rstErr", 32'(err), 32'd0);
      checkOutput("rstAddA", add_a, 32'h0);
      checkOutput("rstAddB", add_b, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idleBusy", 32'(busy), 32'd0);

      $display("[TB] 1.0 + 2.0");
      vec = '{32'h3F800000, 32'h40000000};
      startRun();
      sendAll();
      expectDone(32'h40400000, 1'b0);
      finishRun();

      $display("[TB] 1.0 + 1.0 + 2.0");
      vec = '{32'h3F800000, 32'h3F800000, 32'h40000000};
      startRun();
      applyStimulus(vec[0]);
      applyStimulus(vec[1]);
      in_valid = 1'b0;
      n = 0;
      while (!in_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("accAfterBeat2", add_a, 32'h40000000);
      applyStimulus(vec[2]);
      in_valid = 1'b0;
      expectDone(32'h40800000, 1'b0);
      finishRun();

      $display("[TB] single element and empty run");
      vec = '{32'h3FC00000};
      startRun();
      sendAll();
      expectDone(32'h3FC00000, 1'b0);
      finishRun();
      vec.delete();
      startRun();
      expectDone(32'h00000000, 1'b0);
      finishRun();

      $display("[TB] backpressure");
      vec = '{32'h40000000, 32'h40000000};
      startRun();
      checkOutput("inReadyInAcc", 32'(in_ready), 32'd1);
      applyStimulus(vec[0]);
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("inReadyGap", 32'(in_ready), 32'd1);
      applyStimulus(vec[1]);
      in_valid = 1'b0;
      expectDone(32'h40800000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("holdValid", 32'(out_valid), 32'd1);
         checkOutput("holdData", out_data, 32'h40800000);
         checkOutput("holdNoReady", 32'(in_ready), 32'd0);
         start = (i == 2);
         len   = CNT_W'(1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      start     = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      start     = 1'b0;
      checkOutput("ackWithStartIdle", 32'(busy), 32'd0);
      checkOutput("ackWithStartValid", 32'(out_valid), 32'd0);
      @(negedge clk);
      checkOutput("startDropped", 32'(busy), 32'd0);

      $display("[TB] negative element sets err");
      vec = '{32'hBF800000, 32'h3F800000};
      startRun();
      sendAll();
      expectDone(32'h40000000, 1'b1);
      finishRun();
      vec = '{32'h40000000};
      startRun();
      checkOutput("errClearedByStart", 32'(err), 32'd0);
      sendAll();
      expectDone(32'h40000000, 1'b0);
      finishRun();

      $display("[TB] adder overflow sets err");
      vec = '{32'h7F000000, 32'h7F000000};
      startRun();
      sendAll();
      expectDone(32'h7F800000, 1'b1);
      finishRun();

      $display("[TB] reset mid-run");
      vec = '{32'hBF800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
      startRun();
      applyStimulus(vec[0]);
      checkOutput("errBeforeReset", 32'(err), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("abortBusy", 32'(busy), 32'd0);
      checkOutput("abortInReady", 32'(in_ready), 32'd0);
      checkOutput("abortOutValid", 32'(out_valid), 32'd0);
      checkOutput("abortErr", 32'(err), 32'd0);
      expSum.delete();
      expErr.delete();
      in_valid = 1'b0;
      in_data  = 32'h0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vec = '{32'h40000000};
      startRun();
      sendAll();
      expectDone(32'h40000000, 1'b0);
      finishRun();

      checkOutput("pendingResults", 32'(expSum.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
